// File: rtl/fb_pkg.sv
// fb_pkg: shared widths, swap FSM states and bank address helper for the frame buffer arbiter
package fb_pkg;
  localparam int DEF_OFF_W = 8;
  localparam int DEF_DATA_W = 8;
  typedef enum logic {ST_IDLE, ST_PENDING} swap_st_e;
  function automatic logic [31:0] bank_addr(input logic bank, input logic [30:0] off, input int off_w);
    return ({31'd0, bank} << off_w) | {1'b0, off};
  endfunction
endpackage

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: display read and host write channels of the frame buffer arbiter
interface fb_arbiter_if import fb_pkg::*; #(
  parameter int OFF_W = DEF_OFF_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic disp_rd;
  logic [OFF_W-1:0] disp_raddr;
  logic disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic host_wvalid;
  logic host_wready;
  logic [OFF_W-1:0] host_waddr;
  logic [DATA_W-1:0] host_wdata;
  modport master(
    output disp_rd, disp_raddr, host_wvalid, host_waddr, host_wdata,
    input disp_rvalid, disp_rdata, host_wready
  );
  modport slave(
    input disp_rd, disp_raddr, host_wvalid, host_waddr, host_wdata,
    output disp_rvalid, disp_rdata, host_wready
  );
endinterface

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: bank swap FSM that defers a requested swap to the next frame sync
module fb_swap_ctrl import fb_pkg::*; (
  input  logic       clk,
  input  logic       nrst,
  input  logic       swap_req,
  input  logic       frame_sync,
  output logic       front_bank,
  output logic       swap_pending,
  output logic [7:0] frame_count
);
  swap_st_e state_q, state_d;
  logic front_q, front_d;
  logic [7:0] cnt_q, cnt_d;
  logic swap_now;
  // next state: a sync only completes a swap already waiting, so a same-cycle request just arms it
  always_comb begin
    swap_now = (state_q == ST_PENDING) && frame_sync;
    state_d = swap_now ? ST_IDLE : (swap_req ? ST_PENDING : state_q);
    front_d = front_q ^ swap_now;
    cnt_d = cnt_q + {7'd0, swap_now};
  end
  // state registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      front_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      cnt_q <= cnt_d;
    end
  end
  assign front_bank = front_q;
  assign swap_pending = (state_q == ST_PENDING);
  assign frame_count = cnt_q;
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port RAM arbiter giving display reads priority over host writes to the back bank
module fb_arbiter import fb_pkg::*; #(
  parameter int OFF_W = DEF_OFF_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              nrst,
  fb_arbiter_if.slave       bus,
  input  logic              swap_req,
  input  logic              frame_sync,
  output logic              front_bank,
  output logic              swap_pending,
  output logic [7:0]        frame_count,
  output logic [OFF_W:0]    mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic fb, pend;
  logic [7:0] cnt;
  logic wready, acc;
  logic [OFF_W:0] addr_q, addr_d;
  logic we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic rd_q, rd_d;
  logic rv_q, rv_d;
  fb_swap_ctrl u_swap (
    .clk(clk),
    .nrst(nrst),
    .swap_req(swap_req),
    .frame_sync(frame_sync),
    .front_bank(fb),
    .swap_pending(pend),
    .frame_count(cnt)
  );
  // arbitration: reads win, writes target the bank that is back at acceptance time
  always_comb begin
    wready = !bus.disp_rd && !pend && nrst;
    acc = bus.host_wvalid && wready;
    addr_d = bus.disp_rd ? (OFF_W+1)'(bank_addr(fb, 31'(bus.disp_raddr), OFF_W))
           : acc ? (OFF_W+1)'(bank_addr(!fb, 31'(bus.host_waddr), OFF_W))
           : addr_q;
    we_d = acc;
    wdata_d = acc ? bus.host_wdata : wdata_q;
    rd_d = bus.disp_rd;
    rv_d = rd_q;
  end
  // RAM request stage and read-valid pipeline
  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      rv_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      rv_q <= rv_d;
    end
  end
  assign bus.host_wready = wready;
  assign bus.disp_rvalid = rv_q && nrst;
  assign bus.disp_rdata = (rv_q && nrst) ? mem_rdata : '0;
  assign mem_addr = nrst ? addr_q : '0;
  assign mem_we = we_q && nrst;
  assign mem_wdata = nrst ? wdata_q : '0;
  assign front_bank = fb && nrst;
  assign swap_pending = pend && nrst;
  assign frame_count = nrst ? cnt : 8'd0;
endmodule
